// File: rtl/pwm_cmd_pkg.sv
// Shared constants for the PWM command controller: framing bytes, function codes, status codes, FSM encoding.
// Latency: n/a (constants only).
// Backpressure: n/a.
package pwm_cmd_pkg;

    localparam logic [7:0] HDR      = 8'h55;
    localparam logic [7:0] FTR      = 8'hAA;
    localparam logic [7:0] RSP_HDR  = 8'h5A;
    localparam logic [7:0] RSP_FTR  = 8'hA5;

    localparam logic [7:0] FUNC_CFG = 8'h01;
    localparam logic [7:0] FUNC_EN  = 8'h02;

    localparam logic [7:0] ST_OK    = 8'h00;
    localparam logic [7:0] ST_CRC   = 8'h01;
    localparam logic [7:0] ST_CH    = 8'h02;
    localparam logic [7:0] ST_FUNC  = 8'h03;
    localparam logic [7:0] ST_BUSY  = 8'h04;
    localparam logic [7:0] ST_FTR   = 8'h05;

    localparam logic [7:0] CRC_POLY = 8'h07;
    localparam int         FRAME_LEN = 14;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RECV = 2'd1;
    localparam logic [1:0] S_EXEC = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

endpackage

// File: rtl/crc8_byte.sv
// One-byte CRC-8 step (poly 0x07, MSB first, non-reflected).
// Latency: combinational.
// Backpressure: none.
module crc8_byte
    import pwm_cmd_pkg::*;
(
    input  logic [7:0] crc_in,
    input  logic [7:0] data,
    output logic [7:0] crc_out
);

    // Eight shift/xor steps over the byte, MSB first
    always_comb begin
        logic [7:0] c;
        c = crc_in ^ data;
        for (int b = 0; b < 8; b++) begin
            c = c[7] ? ((c << 1) ^ CRC_POLY) : (c << 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/pwm_cmd_ctrl.sv
// Frames 14-byte host packets, checks CRC, writes channel config or enable mask, replies with 4-byte status.
// Latency: footer byte in cycle N -> cfg_wr / ch_en update / first reply byte visible in cycle N+2.
// Backpressure: reply bytes held until tx_ready; rx bytes arriving outside IDLE/RECV are dropped.
module pwm_cmd_ctrl
    import pwm_cmd_pkg::*;
#(
    parameter int _PAT_WIDTH    = 32,
    parameter int _NUM_CHANNELS = 6,
    parameter int TIMEOUT_CYC   = 50000
)
(
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic [7:0]               rx_data,
    input  logic                     rx_valid,
    output logic [7:0]               tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic                     cfg_wr,
    output logic [7:0]               cfg_ch,
    output logic [7:0]               cfg_duty,
    output logic [15:0]              cfg_dessert,
    output logic [7:0]               cfg_pulse_num,
    output logic [_PAT_WIDTH-1:0]    cfg_pat,
    output logic [_NUM_CHANNELS-1:0] ch_en,
    output logic [7:0]               err_cnt
);

    localparam int GAP_W = $clog2(TIMEOUT_CYC + 1) + 1;

    logic [1:0]                state_q, state_d;
    logic [3:0]                idx_q, idx_d;
    logic [GAP_W-1:0]          gap_q, gap_d;
    logic [7:0]                crc_q, crc_d, crc_nxt;
    logic [7:0]                func_q, func_d, ch_q, ch_d, duty_q, duty_d, pnum_q, pnum_d;
    logic                      sta0_q, sta0_d;
    logic [15:0]               dsrt_q, dsrt_d;
    logic [_PAT_WIDTH-1:0]     pat_q, pat_d;
    logic [7:0]                crc_rx_q, crc_rx_d, ftr_q, ftr_d, status_q, status_d;
    logic [1:0]                rsp_idx_q, rsp_idx_d;
    logic [7:0]                tx_data_q, tx_data_d;
    logic                      tx_valid_q, tx_valid_d, cfg_wr_q, cfg_wr_d;
    logic [7:0]                cfg_ch_q, cfg_ch_d, cfg_duty_q, cfg_duty_d, cfg_pnum_q, cfg_pnum_d;
    logic [15:0]               cfg_dsrt_q, cfg_dsrt_d;
    logic [_PAT_WIDTH-1:0]     cfg_pat_q, cfg_pat_d;
    logic [_NUM_CHANNELS-1:0]  ch_en_q, ch_en_d, ch_sel;
    logic [7:0]                err_q, err_d, status_calc;

    crc8_byte u_crc (
        .crc_in  (crc_q),
        .data    (rx_data),
        .crc_out (crc_nxt)
    );

    // Decode the received frame into a status code (first failing check wins)
    always_comb begin
        for (int k = 0; k < _NUM_CHANNELS; k++) begin
            ch_sel[k] = (ch_q == 8'(k + 1));
        end
        if (ftr_q != FTR)                                 status_calc = ST_FTR;
        else if (crc_rx_q != crc_q)                       status_calc = ST_CRC;
        else if (ch_sel == '0)                            status_calc = ST_CH;
        else if (func_q != FUNC_CFG && func_q != FUNC_EN) status_calc = ST_FUNC;
        else if (func_q == FUNC_CFG && (ch_en_q & ch_sel) != '0) status_calc = ST_BUSY;
        else                                              status_calc = ST_OK;
    end

    // Next-state logic for framing, execution and reply
    always_comb begin
        state_d = state_q;   idx_d = idx_q;     gap_d = gap_q;       crc_d = crc_q;
        func_d = func_q;     ch_d = ch_q;       sta0_d = sta0_q;     duty_d = duty_q;
        dsrt_d = dsrt_q;     pnum_d = pnum_q;   pat_d = pat_q;       crc_rx_d = crc_rx_q;
        ftr_d = ftr_q;       status_d = status_q; rsp_idx_d = rsp_idx_q;
        tx_data_d = tx_data_q; tx_valid_d = tx_valid_q; cfg_wr_d = 1'b0;
        cfg_ch_d = cfg_ch_q; cfg_duty_d = cfg_duty_q; cfg_dsrt_d = cfg_dsrt_q;
        cfg_pnum_d = cfg_pnum_q; cfg_pat_d = cfg_pat_q; ch_en_d = ch_en_q; err_d = err_q;
        case (state_q)
            S_IDLE: begin
                if (rx_valid && rx_data == HDR) begin
                    state_d = S_RECV;
                    idx_d   = 4'd1;
                    gap_d   = '0;
                    crc_d   = 8'h00;
                end
            end
            S_RECV: begin
                if (rx_valid) begin
                    gap_d = '0;
                    idx_d = idx_q + 4'd1;
                    if (idx_q <= 4'd11) crc_d = crc_nxt;
                    case (idx_q)
                        4'd1:  func_d = rx_data;
                        4'd2:  ch_d = rx_data;
                        4'd3:  sta0_d = rx_data[0];
                        4'd4:  duty_d = rx_data;
                        4'd5:  dsrt_d[15:8] = rx_data;
                        4'd6:  dsrt_d[7:0] = rx_data;
                        4'd7:  pnum_d = rx_data;
                        4'd8, 4'd9, 4'd10, 4'd11: pat_d = _PAT_WIDTH'({pat_q, rx_data});
                        4'd12: crc_rx_d = rx_data;
                        default: ftr_d = rx_data;
                    endcase
                    if (idx_q == 4'(FRAME_LEN - 1)) state_d = S_EXEC;
                end else if (gap_q >= GAP_W'(TIMEOUT_CYC)) begin
                    // Host went quiet mid-frame: drop it without a reply
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            S_EXEC: begin
                status_d   = status_calc;
                tx_valid_d = 1'b1;
                tx_data_d  = RSP_HDR;
                rsp_idx_d  = 2'd0;
                state_d    = S_RESP;
                if (status_calc == ST_OK) begin
                    if (func_q == FUNC_CFG) begin
                        cfg_wr_d   = 1'b1;
                        cfg_ch_d   = ch_q;
                        cfg_duty_d = duty_q;
                        cfg_dsrt_d = dsrt_q;
                        cfg_pnum_d = pnum_q;
                        cfg_pat_d  = pat_q;
                    end else begin
                        ch_en_d = sta0_q ? (ch_en_q | ch_sel) : (ch_en_q & ~ch_sel);
                    end
                end else if (err_q != 8'hFF) begin
                    err_d = err_q + 8'd1;
                end
            end
            default: begin
                if (tx_valid_q && tx_ready) begin
                    rsp_idx_d = rsp_idx_q + 2'd1;
                    case (rsp_idx_q)
                        2'd0: tx_data_d = status_q;
                        2'd1: tx_data_d = ch_q;
                        2'd2: tx_data_d = RSP_FTR;
                        default: begin
                            tx_data_d  = 8'h00;
                            tx_valid_d = 1'b0;
                            state_d    = S_IDLE;
                        end
                    endcase
                end
            end
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            state_q <= S_IDLE;  idx_q <= '0;     gap_q <= '0;      crc_q <= '0;
            func_q <= '0;       ch_q <= '0;      sta0_q <= 1'b0;   duty_q <= '0;
            dsrt_q <= '0;       pnum_q <= '0;    pat_q <= '0;      crc_rx_q <= '0;
            ftr_q <= '0;        status_q <= '0;  rsp_idx_q <= '0;  tx_data_q <= '0;
            tx_valid_q <= 1'b0; cfg_wr_q <= 1'b0; cfg_ch_q <= '0;  cfg_duty_q <= '0;
            cfg_dsrt_q <= '0;   cfg_pnum_q <= '0; cfg_pat_q <= '0; ch_en_q <= '0;
            err_q <= '0;
        end else begin
            state_q <= state_d;   idx_q <= idx_d;       gap_q <= gap_d;       crc_q <= crc_d;
            func_q <= func_d;     ch_q <= ch_d;         sta0_q <= sta0_d;     duty_q <= duty_d;
            dsrt_q <= dsrt_d;     pnum_q <= pnum_d;     pat_q <= pat_d;       crc_rx_q <= crc_rx_d;
            ftr_q <= ftr_d;       status_q <= status_d; rsp_idx_q <= rsp_idx_d; tx_data_q <= tx_data_d;
            tx_valid_q <= tx_valid_d; cfg_wr_q <= cfg_wr_d; cfg_ch_q <= cfg_ch_d; cfg_duty_q <= cfg_duty_d;
            cfg_dsrt_q <= cfg_dsrt_d; cfg_pnum_q <= cfg_pnum_d; cfg_pat_q <= cfg_pat_d; ch_en_q <= ch_en_d;
            err_q <= err_d;
        end
    end

    assign tx_data       = tx_data_q;
    assign tx_valid      = tx_valid_q;
    assign cfg_wr        = cfg_wr_q;
    assign cfg_ch        = cfg_ch_q;
    assign cfg_duty      = cfg_duty_q;
    assign cfg_dessert   = cfg_dsrt_q;
    assign cfg_pulse_num = cfg_pnum_q;
    assign cfg_pat       = cfg_pat_q;
    assign ch_en         = ch_en_q;
    assign err_cnt       = err_q;

endmodule

// File: doc/pwm_cmd_ctrl.md
Name: pwm_cmd_ctrl

Overview:
UART command controller that sequences the PWM channel bank. It frames the 14-byte host packet (0x55 … 0xAA) arriving from the UART receiver and checks its CRC. It then decodes the function code and either writes one channel's config registers or updates the channel enable mask. Every accepted frame is answered with a 4-byte status reply through the UART transmitter. The block sits between uart_rx/uart_tx and the PWM channel array inside the top-level.

Parameters:
_PAT_WIDTH, 32, pattern width driven to channels; at most 32; taken from the low bits of the 32-bit pattern field.
_NUM_CHANNELS, 6, number of addressable channels; valid channel byte is 1.._NUM_CHANNELS.
TIMEOUT_CYC, 50000, maximum idle cycles between bytes inside a frame (1 ms at 50 MHz).

Ports:
sys_clk  in  1  system clock, 50 MHz
sys_rst  in  1  synchronous, active-low reset
rx_data  in  8  received UART byte
rx_valid  in  1  one-cycle strobe; rx_data is valid
tx_data  out  8  reply byte
tx_valid  out  1  reply byte valid; held until tx_ready
tx_ready  in  1  transmitter can accept; transfer occurs when tx_valid&&tx_ready
cfg_wr  out  1  one-cycle config write strobe
cfg_ch  out  8  target channel (1-based)
cfg_duty  out  8  duty_num field
cfg_dessert  out  16  pulse_dessert {H,L}
cfg_pulse_num  out  8  pulse_num field
cfg_pat  out  _PAT_WIDTH  pattern, big-endian from bytes 8..11
ch_en  out  _NUM_CHANNELS  enable mask; bit k is channel k+1
err_cnt  out  8  saturating count of rejected frames

Behaviour:
- Reset (sys_rst low at a sys_clk edge): state=IDLE. All outputs are 0: cfg_*, ch_en, err_cnt, tx_valid, tx_data.
- Frame layout, byte index 0..13: 0 hdr=0x55, 1 func, 2 ch, 3 sta, 4 duty, 5 dsrt_h, 6 dsrt_l, 7 pnum, 8..11 pat MSB first, 12 crc, 13 ftr=0xAA.
- CRC: CRC-8, poly 0x07, init 0x00, non-reflected, no final xor, computed over bytes 1..11.
- FSM IDLE: on a rx_valid with byte 0x55, load 0 into the CRC and go to RECV with idx=1. Any other byte is ignored.
- FSM RECV: each rx_valid stores the byte at idx, updates the CRC for idx 1..11, and increments idx. At idx 13 the byte is checked and the FSM goes to EXEC.
- RECV timeout: an inter-byte gap greater than TIMEOUT_CYC cycles returns the FSM to IDLE silently. No reply is sent and err_cnt is unchanged.
- A 0x55 byte inside RECV is treated as data. Resynchronisation happens only through timeout or frame end.
- FSM EXEC (exactly 1 cycle): evaluates the status checks in this priority order:
  - Footer not equal to 0xAA: status 0x05.
  - CRC mismatch: status 0x01.
  - ch equal to 0 or greater than _NUM_CHANNELS: status 0x02.
  - func not 0x01 or 0x02: status 0x03.
  - func 0x01 while ch_en[ch-1]=1: status 0x04 (a running channel is never reconfigured).
  - Otherwise: status 0x00.
- EXEC actions on status 0x00:
  - func 0x01: cfg_* are registered and cfg_wr pulses high for 1 cycle.
  - func 0x02: ch_en[ch-1] is set to sta[0].
- EXEC actions on status not 0x00: err_cnt increments, saturating at 255. No write strobe and no ch_en change.
- Timing: if the footer's rx_valid occurs in cycle N, then cfg_wr and the ch_en update are visible in cycle N+2. tx_valid rises in cycle N+2.
- cfg_* hold their last value between writes.
- FSM RESP: sends 4 bytes: 0x5A, status, ch, 0xA5. Each byte is held on tx_data with tx_valid high until tx_ready. After the 4th transfer the FSM goes to IDLE.
- rx_valid received during EXEC or RESP is dropped and not buffered.
- Reset asserted mid-frame or mid-reply aborts immediately. tx_valid drops in the cycle after the reset edge.

Decomposition:
- Shared package pwm_cmd_pkg holds these constants:
  - HDR=0x55, FTR=0xAA, RSP_HDR=0x5A, RSP_FTR=0xA5.
  - FUNC_CFG=0x01, FUNC_EN=0x02.
  - Status codes 0x00..0x05.
  - CRC_POLY=0x07.
  - FRAME_LEN=14.
  - FSM state encoding IDLE/RECV/EXEC/RESP.
- One sub-module, crc8_byte: a combinational next-CRC function taking crc_in[7:0] and data[7:0] and returning crc_out[7:0]. It is instantiated once.

Test Plan:
- Config ch2: func=01, ch=02, sta=00, duty=01, dsrt=0x0001, pnum=00, pat=0x00000001, valid CRC from the bench model. Required: cfg_wr pulses once with cfg_ch=2, cfg_duty=1, cfg_dessert=0x0001, cfg_pat=1; reply 5A 00 02 A5.
- Enable ch1: func=02, ch=01, sta=01, valid CRC. Required: ch_en=6'b000001 at N+2; reply 5A 00 01 A5. Then disable (sta=00): ch_en=0.
- Bad CRC: same frame as the disable but with CRC XOR 0x01. Required: ch_en unchanged, err_cnt +1, reply 5A 01 01 A5, no cfg_wr.
- Reconfigure an enabled channel: func=01 to ch1 while ch_en[0]=1. Required: reply status 04, cfg outputs unchanged. ch=07 → status 02. func=03 → status 03. Footer 0xAB → status 05.
- Timeout: send 5 bytes, idle TIMEOUT_CYC+1 cycles, then send a full valid frame. Required: only the second frame is executed, exactly one reply, err_cnt unchanged.
- Back-pressure and reset: hold tx_ready=0 for 100 cycles. Required: tx_valid stays high with tx_data=0x5A. Assert sys_rst low during the reply: all outputs return to 0 and the FSM is IDLE.
